deser_fifo_ctrl: RTL and testbench

Controller between the byte deserializer and the downstream consumer.
- Watches the deserializer's data_ready/ack handshake, captures each completed byte into an internal FIFO, and acks the deserializer.
- Throttles the serial source through src_enable_out when buffering is exhausted.
- Presents the FIFO head to the consumer with a valid/dequeue handshake.

---
 rtl/deser_ctrl_pkg.sv | 22 ++
 rtl/deser_fifo_ctrl_if.sv | 44 ++++
 rtl/byte_fifo.sv | 68 ++++++
 rtl/deser_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_deser_fifo_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/deser_ctrl_pkg.sv
// Shared types and constants for the deserializer-to-consumer FIFO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package deser_ctrl_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int BYTE_W        = 8;

  // Ingress handshake with the deserializer.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } ingress_state_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/deser_fifo_ctrl_if.sv
// Bundles the deserializer handshake, source throttle and consumer pop signals.
// Latency: n/a (wiring only).
// Backpressure: carried by des_ack_out / src_enable_out / data_valid + deq_in.
interface deser_fifo_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);

  logic                     des_data_ready;
  logic [WIDTH-1:0]         des_data_in;
  logic                     des_status_in;
  logic                     des_ack_out;
  logic                     src_enable_out;
  logic                     deq_in;
  logic [WIDTH-1:0]         data_out;
  logic                     data_valid;
  logic [$clog2(DEPTH):0]   len_out;
  logic                     full_out;
  logic                     empty_out;
`ifdef DROP_OLDEST_EN
  logic [7:0]               drop_count_out;
`endif

  // Environment side: deserializer + consumer.
  modport master (
    output des_data_ready, des_data_in, des_status_in, deq_in,
    input  des_ack_out, src_enable_out, data_out, data_valid,
    input  len_out, full_out, empty_out
`ifdef DROP_OLDEST_EN
    , input drop_count_out
`endif
  );

  // Controller side.
  modport slave (
    input  des_data_ready, des_data_in, des_status_in, deq_in,
    output des_ack_out, src_enable_out, data_out, data_valid,
    output len_out, full_out, empty_out
`ifdef DROP_OLDEST_EN
    , output drop_count_out
`endif
  );

endinterface

// File: rtl/byte_fifo.sv
// Circular byte FIFO with registered head, count, full, empty and valid.
// Latency: a push is visible at head one cycle later; a pop advances head next cycle.
// Backpressure: push refused when full unless ovr is set (then oldest entry is dropped).
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clock_100KHz,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   ovr,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_nxt;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  // Push is judged on the registered full flag, before any same-cycle pop;
  // with ovr a push into a full FIFO forces the oldest entry out.
  always_comb begin
    do_pop    = (pop && !empty) || (push && full && ovr);
    do_push   = push && (!full || ovr);
    rd_nxt    = rd_ptr + PW'(do_pop);
    count_nxt = count + CW'(do_push) - CW'(do_pop);
  end

  // Storage write; contents need no reset because valid/count gate them.
  always_ff @(posedge clock_100KHz) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy flags and the registered head word.
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_ptr + PW'(do_push);
      count  <= count_nxt;
      full   <= (count_nxt == CW'(DEPTH));
      empty  <= (count_nxt == '0);
      valid  <= (count_nxt != '0);
      // Bypass when the byte being written becomes the new head.
      head   <= (do_push && (wr_ptr == rd_nxt)) ? din : mem[rd_nxt];
    end
  end

endmodule

// File: rtl/deser_fifo_ctrl.sv
// Captures deserializer bytes into a FIFO, acks them, and serves them to a consumer.
// Latency: ack rises 2 cycles after data_ready is seen with space; byte at head 2 cycles after.
// Backpressure: stalls ingress when full (or drops oldest with DROP_OLDEST_EN); src_enable throttles source.
module deser_fifo_ctrl
  import deser_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = BYTE_W
) (
  input  logic             clock_100KHz,
  input  logic             reset,
  deser_fifo_ctrl_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);

`ifdef DROP_OLDEST_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  ingress_state_t   state;
  logic             ack;
  logic             src_en;
  logic             fifo_push;
  logic [WIDTH-1:0] fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_valid;

  assign fifo_push = (state == PUSH);

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .push         (fifo_push),
    .pop          (bus.deq_in),
    .ovr          (DROP_EN),
    .din          (bus.des_data_in),
    .head         (fifo_head),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .valid        (fifo_valid)
  );

  // Ingress handshake: capture once, ack one cycle, wait for data_ready to drop.
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (bus.des_data_ready && (!fifo_full || DROP_EN)) state <= PUSH;
        end
        PUSH: begin
          state <= ACK;
          ack   <= 1'b1;
        end
        ACK: begin
          state <= RELEASE;
          ack   <= 1'b0;
        end
        RELEASE: begin
          ack <= 1'b0;
          if (!bus.des_data_ready) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  // Source throttle; without dropping, one slot is kept for the byte in flight.
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      src_en <= 1'b0;
    end else begin
`ifdef DROP_OLDEST_EN
      src_en <= bus.des_status_in;
`else
      src_en <= bus.des_status_in && (fifo_count < CW'(DEPTH - 1));
`endif
    end
  end

`ifdef DROP_OLDEST_EN
  logic [7:0] drop_cnt;
  logic       drop_now;

  // A push into a full FIFO with no consumer pop discards the oldest byte.
  assign drop_now = fifo_push && fifo_full && !bus.deq_in;

  // Saturating count of discarded bytes.
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (drop_now && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.drop_count_out = drop_cnt;
`endif

  assign bus.des_ack_out    = ack;
  assign bus.src_enable_out = src_en;
  assign bus.data_out       = fifo_head;
  assign bus.data_valid     = fifo_valid;
  assign bus.len_out        = fifo_count;
  assign bus.full_out       = fifo_full;
  assign bus.empty_out      = fifo_empty;

endmodule

// File: tb/tb_deser_fifo_ctrl.sv
// Directed self-checking bench for deser_fifo_ctrl (DEPTH=8, WIDTH=8).
// Latency: checks 2-cycle ack latency and 1-cycle pop-to-head update.
// Backpressure: exercises full stall, src_enable throttle, and drop-oldest when DROP_OLDEST_EN.
module tb_deser_fifo_ctrl;

  logic clock_100KHz = 1'b0;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  deser_fifo_ctrl_if #(.DEPTH(8), .WIDTH(8)) bus ();

  deser_fifo_ctrl #(.DEPTH(8), .WIDTH(8)) dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .bus          (bus.slave)
  );

  always #5 clock_100KHz = ~clock_100KHz;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; sample/drive 1 ns after it.
  task automatic step();
    @(posedge clock_100KHz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.des_data_ready = 1'b0;
    bus.deq_in = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  // Steps until ack is seen, bounded; n is the number of edges taken.
  task automatic wait_ack(output int n);
    n = 0;
    while (!bus.des_ack_out && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    bus.des_data_in = b;
    bus.des_data_ready = 1'b1;
    wait_ack(n);
    check_eq("ack_latency", n, 2);
    bus.des_data_ready = 1'b0;
    step();
    check_eq("ack_one_cycle", bus.des_ack_out, 0);
    step();
  endtask

  initial begin
    int n;
    int acks;
    reset = 1'b1;
    bus.des_data_ready = 1'b0;
    bus.des_data_in = 8'h00;
    bus.des_status_in = 1'b1;
    bus.deq_in = 1'b0;
    step();
    step();

    // 1. reset state
    check_eq("rst_empty", bus.empty_out, 1);
    check_eq("rst_valid", bus.data_valid, 0);
    check_eq("rst_ack", bus.des_ack_out, 0);
    check_eq("rst_len", bus.len_out, 0);
    check_eq("rst_full", bus.full_out, 0);
    check_eq("rst_src_en", bus.src_enable_out, 0);
    check_eq("rst_data", bus.data_out, 0);
    reset = 1'b0;
    step();
    step();
    check_eq("idle_len", bus.len_out, 0);
    check_eq("idle_src_en", bus.src_enable_out, 1);

    // 2. single byte
    push_byte(8'hA5);
    check_eq("one_len", bus.len_out, 1);
    check_eq("one_data", bus.data_out, 8'hA5);
    check_eq("one_valid", bus.data_valid, 1);
    check_eq("one_empty", bus.empty_out, 0);

    // 3. fill to full, then stall
    do_reset();
    for (int i = 1; i <= 8; i++) push_byte(i[7:0]);
    check_eq("fill_full", bus.full_out, 1);
    check_eq("fill_len", bus.len_out, 8);
    check_eq("fill_head", bus.data_out, 8'h01);
`ifndef DROP_OLDEST_EN
    check_eq("fill_src_en", bus.src_enable_out, 0);
    bus.des_data_in = 8'h09;
    bus.des_data_ready = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      acks += int'(bus.des_ack_out);
    end
    check_eq("stall_no_ack", acks, 0);
    bus.deq_in = 1'b1;
    step();
    bus.deq_in = 1'b0;
    check_eq("stall_pop_head", bus.data_out, 8'h02);
    check_eq("stall_pop_len", bus.len_out, 7);
    wait_ack(n);
    check_eq("stall_ack_lat", n, 2);
    bus.des_data_ready = 1'b0;
    step();
    step();
    check_eq("refill_len", bus.len_out, 8);
    check_eq("refill_full", bus.full_out, 1);
`endif

    // 4. drain in order, then pop while empty
    do_reset();
    for (int i = 1; i <= 8; i++) push_byte(i[7:0]);
    bus.deq_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check_eq("drain_data", bus.data_out, i);
      check_eq("drain_valid", bus.data_valid, 1);
      step();
    end
    bus.deq_in = 1'b0;
    check_eq("drain_len", bus.len_out, 0);
    check_eq("drain_empty", bus.empty_out, 1);
    check_eq("drain_valid_lo", bus.data_valid, 0);
    bus.deq_in = 1'b1;
    step();
    bus.deq_in = 1'b0;
    step();
    check_eq("empty_pop_len", bus.len_out, 0);
    check_eq("empty_pop_empty", bus.empty_out, 1);

    // 5. simultaneous push/pop at len 3, then wrap with 20 bytes
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    check_eq("pp_len_pre", bus.len_out, 3);
    bus.des_data_in = 8'h34;
    bus.des_data_ready = 1'b1;
    step();
    bus.deq_in = 1'b1;
    step();
    bus.deq_in = 1'b0;
    check_eq("pp_ack", bus.des_ack_out, 1);
    check_eq("pp_len", bus.len_out, 3);
    check_eq("pp_head", bus.data_out, 8'h32);
    bus.des_data_ready = 1'b0;
    step();
    step();
    bus.deq_in = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      check_eq("pp_drain", bus.data_out, 8'h30 + i);
      step();
    end
    bus.deq_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_byte(8'h40 + i[7:0]);
      check_eq("wrap_data", bus.data_out, 8'h40 + i);
      bus.deq_in = 1'b1;
      step();
      bus.deq_in = 1'b0;
      check_eq("wrap_empty", bus.empty_out, 1);
    end

    // 6. reset during ACK
    push_byte(8'h11);
    bus.des_data_in = 8'h22;
    bus.des_data_ready = 1'b1;
    wait_ack(n);
    check_eq("mid_ack_seen", bus.des_ack_out, 1);
    check_eq("mid_len", bus.len_out, 2);
    reset = 1'b1;
    #1;
    check_eq("arst_ack", bus.des_ack_out, 0);
    check_eq("arst_len", bus.len_out, 0);
    check_eq("arst_empty", bus.empty_out, 1);
    check_eq("arst_valid", bus.data_valid, 0);
    bus.des_data_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    check_eq("post_arst_len", bus.len_out, 0);

`ifdef DROP_OLDEST_EN
    do_reset();
    for (int i = 1; i <= 9; i++) push_byte(i[7:0]);
    check_eq("drop_head", bus.data_out, 8'h02);
    check_eq("drop_len", bus.len_out, 8);
    check_eq("drop_count", bus.drop_count_out, 1);
    check_eq("drop_src_en", bus.src_enable_out, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
